cordic: RTL and testbench

Iterative rotation-mode CORDIC engine that rotates the fixed-point vector (x_start, y_start) by a signed radian angle, one micro-rotation per clock. With x_start = 1/K (0x26DD) and y_start = 0, it returns cos(angle) and sin(angle) in Q2.14. It is a shared trig/rotation primitive with a start/done handshake for use by control or DSP datapaths.

---
 rtl/cordic.sv | 156 +++++++++++++++
 tb/tb_cordic.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic.sv
// Iterative rotation-mode CORDIC: rotates (x_start, y_start) by a signed Q3.(ANGLE_WIDTH-3)
// radian angle, one micro-rotation per clock, with quadrant pre-rotation and output saturation.
module cordic #(
   parameter int WIDTH       = 16,
   parameter int ITERATIONS  = 15,
   parameter int ANGLE_WIDTH = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic signed [WIDTH-1:0]       x_start,
   input  logic signed [WIDTH-1:0]       y_start,
   input  logic signed [ANGLE_WIDTH-1:0] angle,
   output logic signed [WIDTH-1:0]       cosine,
   output logic signed [WIDTH-1:0]       sine,
   output logic                          done
);

   localparam int XW = WIDTH + 2;
   localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

   // Constants are tabulated in Q3.29 and rescaled to the configured angle width.
   function automatic logic signed [ANGLE_WIDTH-1:0] q329(input logic signed [31:0] v);
      logic signed [63:0] w;
      w = 64'(v);
      return ANGLE_WIDTH'((ANGLE_WIDTH <= 32) ? (w >>> (32 - ANGLE_WIDTH))
                                              : (w <<< (ANGLE_WIDTH - 32)));
   endfunction

   function automatic logic signed [31:0] atan_q329(input int unsigned i);
      case (i)
         0:       return 32'sd421657428;
         1:       return 32'sd248918915;
         2:       return 32'sd131521918;
         3:       return 32'sd66762579;
         4:       return 32'sd33510843;
         5:       return 32'sd16771758;
         6:       return 32'sd8387925;
         7:       return 32'sd4194219;
         8:       return 32'sd2097141;
         9:       return 32'sd1048575;
         default: return (i < 30) ? (32'sd1 <<< (29 - i)) : '0;
      endcase
   endfunction

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
      if (v[XW-1:WIDTH-1] == '0 || v[XW-1:WIDTH-1] == '1) return v[WIDTH-1:0];
      return v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   localparam logic signed [ANGLE_WIDTH-1:0] HALF_PI = q329(32'sh3243F6A9);
   localparam logic signed [ANGLE_WIDTH-1:0] PI      = q329(32'sh6487ED51);

   state_t                          state_q, state_d;
   logic        [CW-1:0]            i_q, i_d;
   logic signed [XW-1:0]            x_q, x_d, y_q, y_d;
   logic signed [ANGLE_WIDTH-1:0]   z_q, z_d;
   logic signed [WIDTH-1:0]         cos_q, cos_d, sin_q, sin_d;
   logic                            done_q, done_d;
   logic signed [XW-1:0]            x_ext, y_ext, x_sh, y_sh;
   logic signed [ANGLE_WIDTH-1:0]   atan_i;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         i_q     <= '0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cos_q   <= '0;
         sin_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = ROTATE;
         ROTATE:     if (i_q == LAST) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      i_d    = i_q;
      x_d    = x_q;
      y_d    = y_q;
      z_d    = z_q;
      cos_d  = cos_q;
      sin_d  = sin_q;
      done_d = done_q;
      x_ext  = {{2{x_start[WIDTH-1]}}, x_start};
      y_ext  = {{2{y_start[WIDTH-1]}}, y_start};
      x_sh   = x_q >>> i_q;
      y_sh   = y_q >>> i_q;
      atan_i = q329(atan_q329(32'(i_q)));
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               done_d = 1'b0;
               i_d    = '0;
               // Fold angles beyond +/-pi/2 by a half-turn so z stays inside CORDIC convergence.
               if (angle > HALF_PI) begin
                  z_d = angle - PI;
                  x_d = -x_ext;
                  y_d = -y_ext;
               end else if (angle < -HALF_PI) begin
                  z_d = angle + PI;
                  x_d = -x_ext;
                  y_d = -y_ext;
               end else begin
                  z_d = angle;
                  x_d = x_ext;
                  y_d = y_ext;
               end
            end
         end
         ROTATE: begin
            if (!z_q[ANGLE_WIDTH-1]) begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_i;
            end else begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_i;
            end
            i_d = i_q + 1'b1;
            if (i_q == LAST) begin
               cos_d  = sat(x_d);
               sin_d  = sat(y_d);
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign cosine = cos_q;
   assign sine   = sin_q;
   assign done   = done_q;

endmodule

// File: tb/tb_cordic.sv
// Self-checking bench for cordic: results are compared against real-valued trig
// and ideal CORDIC gain, with handshake timing counted in clock edges.
module tb_cordic;
   localparam int W   = 16;
   localparam int N   = 15;
   localparam int AW  = 32;
   localparam int TOL = 33;
   localparam logic signed [W-1:0] XK = 16'sh26DD;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic                  start = 1'b0;
   logic signed [W-1:0]   x_start = '0;
   logic signed [W-1:0]   y_start = '0;
   logic signed [AW-1:0]  angle = '0;
   logic signed [W-1:0]   cosine, sine;
   logic                  done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   cordic #(.WIDTH(W), .ITERATIONS(N), .ANGLE_WIDTH(AW)) dut (
      .clock(clock), .reset(reset), .start(start),
      .x_start(x_start), .y_start(y_start), .angle(angle),
      .cosine(cosine), .sine(sine), .done(done)
   );

   // Ideal unit-vector result: true cos/sin of the Q3.29 angle in Q2.14.
   function automatic int ref_trig(input logic signed [31:0] ang, input bit want_sin);
      real a;
      a = $itor(ang) / 536870912.0;
      return want_sin ? int'($sin(a) * 16384.0) : int'($cos(a) * 16384.0);
   endfunction

   function automatic logic signed [31:0] deg2q(input real d);
      return 32'(longint'(d * 3.141592653589793 / 180.0 * 536870912.0));
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Launch one operation; inputs are scrambled after the load edge.
   task automatic run_op(input logic signed [31:0] ang, input logic signed [W-1:0] xs,
                         input logic signed [W-1:0] ys, output int cyc);
      @(negedge clock);
      angle = ang; x_start = xs; y_start = ys; start = 1'b1;
      @(posedge clock);
      cyc = 1;
      #1;
      start = 1'b0;
      angle = $urandom(); x_start = W'($urandom()); y_start = W'($urandom());
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clock);
         cyc++;
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_tests++;
      if (cosine !== '0 || sine !== '0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: cos=%0d sin=%0d done=%b, want 0 0 0", cosine, sine, done);
      end
      repeat (5) @(negedge clock);
      n_tests++;
      if (cosine !== '0 || sine !== '0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_quiet: cos=%0d sin=%0d done=%b, want 0 0 0", cosine, sine, done);
      end
   endtask

   task automatic test_cardinal;
      logic signed [31:0] angs [4];
      int cyc, ec, es;
      angs = '{32'sh00000000, 32'sh3243F6A9, 32'sh6487ED51, -32'sh3243F6A9};
      foreach (angs[k]) begin
         run_op(angs[k], XK, '0, cyc);
         ec = ref_trig(angs[k], 1'b0);
         es = ref_trig(angs[k], 1'b1);
         n_tests++;
         if (cyc !== N + 1) begin
            n_fail++;
            $display("FAIL cardinal_latency[%0d]: edges=%0d want %0d", k, cyc, N + 1);
         end
         n_tests++;
         if (iabs(int'(cosine) - ec) > TOL || iabs(int'(sine) - es) > TOL) begin
            n_fail++;
            $display("FAIL cardinal[%0d]: cos=%0d sin=%0d want %0d %0d (+/-%0d)",
                     k, cosine, sine, ec, es, TOL);
         end
      end
   endtask

   task automatic test_extremes;
      logic signed [31:0] angs [2];
      int cyc, ec, es;
      angs = '{32'sh7FFFFFFF, 32'sh80000000};
      foreach (angs[k]) begin
         run_op(angs[k], XK, '0, cyc);
         ec = ref_trig(angs[k], 1'b0);
         es = ref_trig(angs[k], 1'b1);
         n_tests++;
         if (cyc !== N + 1 || iabs(int'(cosine) - ec) > TOL || iabs(int'(sine) - es) > TOL) begin
            n_fail++;
            $display("FAIL extreme[%0d]: cos=%0d sin=%0d edges=%0d want %0d %0d %0d",
                     k, cosine, sine, cyc, ec, es, N + 1);
         end
      end
   endtask

   task automatic test_octants;
      real degs [7];
      logic signed [31:0] a;
      int cyc, ec, es;
      // 315 deg lies outside [-4,4) rad, so its equivalent -45 deg is used.
      degs = '{30.0, 45.0, 135.0, 225.0, -45.0, 0.001, -0.001};
      foreach (degs[k]) begin
         a = deg2q(degs[k]);
         run_op(a, XK, '0, cyc);
         ec = ref_trig(a, 1'b0);
         es = ref_trig(a, 1'b1);
         n_tests++;
         if (iabs(int'(cosine) - ec) > TOL || iabs(int'(sine) - es) > TOL) begin
            n_fail++;
            $display("FAIL octant[%0d]: cos=%0d sin=%0d want %0d %0d", k, cosine, sine, ec, es);
         end
      end
   endtask

   task automatic test_random;
      logic signed [31:0] a;
      int cyc, ec, es;
      for (int k = 0; k < 50; k++) begin
         a = $urandom();
         run_op(a, XK, '0, cyc);
         ec = ref_trig(a, 1'b0);
         es = ref_trig(a, 1'b1);
         n_tests++;
         if (cyc !== N + 1 || iabs(int'(cosine) - ec) > TOL || iabs(int'(sine) - es) > TOL) begin
            n_fail++;
            $display("FAIL random[%0d] angle=%h: cos=%0d sin=%0d edges=%0d want %0d %0d %0d",
                     k, a, cosine, sine, cyc, ec, es, N + 1);
         end
      end
   endtask

   task automatic test_saturation;
      logic signed [W-1:0] xs [2];
      real an;
      longint e;
      int cyc;
      an = 1.0;
      for (int i = 0; i < N; i++) an = an * $sqrt(1.0 + 2.0 ** (-2.0 * i));
      xs = '{16'sh7FFF, 16'sh8000};
      foreach (xs[k]) begin
         run_op('0, xs[k], '0, cyc);
         e = longint'(an * $itor(xs[k]));
         if (e > 32767) e = 32767;
         if (e < -32768) e = -32768;
         n_tests++;
         if (int'(cosine) != int'(e) || iabs(int'(sine)) > TOL) begin
            n_fail++;
            $display("FAIL saturate[%0d]: cos=%0d sin=%0d want %0d 0", k, cosine, sine, e);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic signed [31:0] a1, a2;
      logic signed [W-1:0] c_hold, s_hold;
      int cyc, k;
      a1 = deg2q(30.0);
      a2 = deg2q(-120.0);
      @(negedge clock);
      angle = a1; x_start = XK; y_start = '0; start = 1'b1;
      @(posedge clock);
      cyc = 1;
      #1;
      start = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         @(posedge clock);
         cyc++;
         #1;
         if (cyc == 5) begin start = 1'b1; angle = a2; end
         else start = 1'b0;
      end
      n_tests++;
      if (cyc !== N + 1 || iabs(int'(cosine) - ref_trig(a1, 1'b0)) > TOL
          || iabs(int'(sine) - ref_trig(a1, 1'b1)) > TOL) begin
         n_fail++;
         $display("FAIL start_ignored: edges=%0d cos=%0d sin=%0d want %0d %0d %0d",
                  cyc, cosine, sine, N + 1, ref_trig(a1, 1'b0), ref_trig(a1, 1'b1));
      end
      c_hold = cosine;
      s_hold = sine;
      repeat (5) @(posedge clock);
      #1;
      n_tests++;
      if (done !== 1'b1 || cosine !== c_hold || sine !== s_hold) begin
         n_fail++;
         $display("FAIL done_hold: done=%b cos=%0d sin=%0d want 1 %0d %0d",
                  done, cosine, sine, c_hold, s_hold);
      end
      @(negedge clock);
      angle = a2; start = 1'b1;
      @(posedge clock);
      #1;
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL done_fall: done=%b want 0", done);
      end
      k = 1;
      while (done !== 1'b1 && k < 40) begin @(posedge clock); k++; #1; end
      @(posedge clock);
      #1;
      n_tests++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL held_start_pulse: done=%b want 0", done);
      end
      k = 1;
      while (done !== 1'b1 && k < 40) begin @(posedge clock); k++; #1; end
      start = 1'b0;
      n_tests++;
      if (k !== N + 1 || iabs(int'(cosine) - ref_trig(a2, 1'b0)) > TOL
          || iabs(int'(sine) - ref_trig(a2, 1'b1)) > TOL) begin
         n_fail++;
         $display("FAIL held_start_op: edges=%0d cos=%0d sin=%0d want %0d %0d %0d",
                  k, cosine, sine, N + 1, ref_trig(a2, 1'b0), ref_trig(a2, 1'b1));
      end
   endtask

   task automatic test_reset_mid;
      logic signed [31:0] a;
      int cyc;
      bit seen;
      a = deg2q(135.0);
      @(negedge clock);
      angle = a; x_start = XK; y_start = '0; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      n_tests++;
      if (cosine !== '0 || sine !== '0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: cos=%0d sin=%0d done=%b want 0 0 0", cosine, sine, done);
      end
      @(negedge clock);
      reset = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort: done rose after abort, want never");
      end
      a = deg2q(-60.0);
      run_op(a, XK, '0, cyc);
      n_tests++;
      if (cyc !== N + 1 || iabs(int'(cosine) - ref_trig(a, 1'b0)) > TOL
          || iabs(int'(sine) - ref_trig(a, 1'b1)) > TOL) begin
         n_fail++;
         $display("FAIL post_reset_op: edges=%0d cos=%0d sin=%0d want %0d %0d %0d",
                  cyc, cosine, sine, N + 1, ref_trig(a, 1'b0), ref_trig(a, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_cardinal();
      test_extremes();
      test_octants();
      test_random();
      test_saturation();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
